// File: rtl/mem_stage_if.sv
// Request/done bus between the memory-access stage (master) and the data memory (slave).
interface mem_stage_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_done;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_done
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_done
  );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: turns XM load/store into a req/done memory handshake and stalls meanwhile.
// Optional MEM_ALIGN_CHECK_EN: odd addresses are refused, setting sticky align_err and halted.
module mem_stage #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              XM_memRead,
  input  logic              XM_memWrite,
  input  logic [ADDR_W-1:0] XM_aluOut,
  input  logic [DATA_W-1:0] XM_writeData,
  input  logic              XM_flush,
  input  logic              XM_halt,
  mem_stage_if.master       mem,
  output logic [DATA_W-1:0] readData,
  output logic              mem_stall,
  output logic              halted,
  output logic              align_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state;
  logic   pending;
  logic   misaligned;
  logic   issue;

  // Stall is held low during reset so a frozen access cannot stall a pipeline being reset.
  always_comb begin
    pending    = (XM_memRead | XM_memWrite) & ~XM_flush & ~halted;
`ifdef MEM_ALIGN_CHECK_EN
    misaligned = pending & XM_aluOut[0];
`else
    misaligned = 1'b0;
`endif
    issue      = pending & ~misaligned;
    mem_stall  = rst & ((state == S_BUSY) | ((state == S_IDLE) & issue));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      readData      <= '0;
      halted        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if ((XM_halt & ~XM_flush) | misaligned) halted <= 1'b1;
          if (issue) begin
            mem.mem_req   <= 1'b1;
            mem.mem_we    <= XM_memWrite;
            mem.mem_addr  <= XM_aluOut;
            mem.mem_wdata <= XM_writeData;
            state         <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (mem.mem_done) begin
            mem.mem_req <= 1'b0;
            if (!mem.mem_we) readData <= mem.mem_rdata;
            state <= S_DONE;
          end
        end
        // DONE never issues: the instruction still in XM is the one just served.
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                align_err <= 1'b0;
    else if ((state == S_IDLE) & misaligned) align_err <= 1'b1;
  end
`else
  assign align_err = 1'b0;
`endif

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage pipeline, placed between the execute/memory pipeline register and the memory/writeback pipeline register. It turns load/store requests from the XM register into a request/done handshake with a variable-latency data memory. While the access is outstanding it stalls the front of the pipeline. It then presents the load result as `readData` to the MW register.

## Interface
Parameters
- `ADDR_W`, default 16: data-memory address width.
- `DATA_W`, default 16: data word width.

Ports
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `XM_memRead`  in  1  instruction in XM is a load.
- `XM_memWrite`  in  1  instruction in XM is a store.
- `XM_aluOut`  in  ADDR_W  effective address.
- `XM_writeData`  in  DATA_W  store data.
- `XM_flush`  in  1  XM slot is a squashed bubble; no access is made.
- `XM_halt`  in  1  instruction in XM is HALT.
- `mem_req`  out  1  access request to data memory (level).
- `mem_we`  out  1  1 = write, 0 = read; valid while `mem_req`.
- `mem_addr`  out  ADDR_W  registered access address.
- `mem_wdata`  out  DATA_W  registered store data.
- `mem_rdata`  in  DATA_W  read data; valid in the `mem_done` cycle.
- `mem_done`  in  1  one-cycle completion pulse from memory.
- `readData`  out  DATA_W  captured load result, to the MW register.
- `mem_stall`  out  1  freezes PC/FD/DX/XM and inserts a bubble into MW.
- `halted`  out  1  sticky; a HALT has passed this stage.
- `align_err`  out  1  sticky misaligned-access flag (see Configuration).

## Operation
- The FSM has three states: IDLE, BUSY, DONE.
- Access pending: `(XM_memRead|XM_memWrite) & ~XM_flush & ~halted`.
- In IDLE with an access pending:
  - `mem_stall` = 1 (combinational).
  - `mem_addr`, `mem_wdata` and `mem_we` (= `XM_memWrite`) are latched.
  - Next state is BUSY.
- If `XM_memRead` and `XM_memWrite` are both 1, treat the access as a write.
- In BUSY:
  - `mem_req` = 1 and `mem_stall` = 1.
  - Address, data and `mem_we` hold stable.
  - On `mem_done`: if the access is a read, capture `mem_rdata` into `readData`; next state is DONE.
- In DONE:
  - `mem_req` = 0 and `mem_stall` = 0; XM advances at the end of this cycle.
  - No new access is issued, even if one is pending; this prevents re-issuing the frozen instruction.
  - Next state is IDLE.
- `readData` changes only on read completion and retains its value otherwise.
- `mem_done` is ignored in IDLE and DONE.
- `halted` sets when IDLE sees `XM_halt & ~XM_flush`. After that, no further requests are issued and `mem_stall` stays 0.
- A flushed slot never stalls and never issues a request.

## Timing
- Reset values: all outputs 0; state IDLE.
- Reset asserted mid-access: `mem_req` drops immediately (asynchronous) and the outstanding access is abandoned.
- Minimum access cost: with `mem_done` in the first BUSY cycle there are 2 stall cycles (IDLE, BUSY), then DONE.
- General case: `mem_done` n cycles after entering BUSY (n ≥ 0) gives n+2 stall cycles.
- Back-to-back accesses: DONE → IDLE → issue, so consecutive memory instructions are spaced by at least one non-stall cycle.
- `readData` is valid from the DONE cycle onward and is latched by MW at the end of DONE.

## Configuration
- `MEM_ALIGN_CHECK_EN` defined:
  - An access with `XM_aluOut[0]` = 1 issues no request and causes no stall.
  - `align_err` sets (sticky until reset) and `halted` sets in the same cycle.
- `MEM_ALIGN_CHECK_EN` undefined:
  - The full address passes through unchecked.
  - `align_err` is tied to 0.

## Test plan
- Reset: drive `rst` = 0 while in BUSY. Required: `mem_req`, `mem_stall`, `readData`, `halted` all 0 immediately; state IDLE after release.
- Load, `XM_aluOut` = 0x0010, `mem_done` one cycle after `mem_req` with `mem_rdata` = 0xBEEF. Required: `mem_stall` high exactly 2 cycles; `readData` = 0xBEEF in DONE; `mem_req` high 1 cycle.
- Store to 0x0020 of 0x1234 with memory latency 4. Required: `mem_we` = 1, `mem_addr`/`mem_wdata` stable for all 4 BUSY cycles; `readData` unchanged; 5 stall cycles.
- Flushed load (`XM_flush` = 1). Required: no `mem_req`, `mem_stall` = 0. Then HALT followed by a load. Required: `halted` = 1 and no request for the load.
- Two consecutive loads, returning 0x0001 and 0x0002. Required: each issues exactly one request; one non-stall DONE cycle between them; `readData` sequence 0x0001 then 0x0002.
- With `MEM_ALIGN_CHECK_EN` defined: load from 0x0031. Required: no `mem_req`, `align_err` = 1, `halted` = 1. Without the macro: the same stimulus issues a request to `mem_addr` = 0x0031.
